// File: rtl/ssd1306_pkg.sv
// Shared types and constants for the SSD1306 I2C write-side target model.
package ssd1306_pkg;

  localparam int PAGE_W = 3;
  localparam int COL_W  = 7;
  localparam logic [6:0] DEFAULT_I2C_ADDR = 7'h3C;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ACK_A,
    CTRL,
    ACK_C,
    BYTE,
    ACK_B,
    IGNORE
  } i2cState_e;

  localparam logic [7:0] OP_DISP_OFF    = 8'hAE;
  localparam logic [7:0] OP_DISP_ON     = 8'hAF;
  localparam logic [7:0] OP_NORMAL      = 8'hA6;
  localparam logic [7:0] OP_INVERT      = 8'hA7;
  localparam logic [7:0] OP_ADDR_MODE   = 8'h20;
  localparam logic [7:0] OP_CONTRAST    = 8'h81;
  localparam logic [7:0] OP_CHARGE_PUMP = 8'h8D;
  localparam logic [7:0] OP_PAGE_BASE   = 8'hB0;

  function automatic logic isTwoByteOp(input logic [7:0] op);
    return (op == OP_ADDR_MODE) || (op == OP_CONTRAST) || (op == OP_CHARGE_PUMP);
  endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronizes raw SCL/SDA into the clk domain and emits single-cycle
// START, STOP, SCL-rise and SCL-fall pulses.
module i2c_line_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_i,
  input  logic sda_i,
  output logic sdaLevel_o,
  output logic start_o,
  output logic stop_o,
  output logic sclRise_o,
  output logic sclFall_o
);

  logic sclMeta_q, sclSync_q, sclPrev_q;
  logic sdaMeta_q, sdaSync_q, sdaPrev_q;

  // Reset to the idle-bus level so leaving reset never fakes an edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclMeta_q <= 1'b1;
      sclSync_q <= 1'b1;
      sclPrev_q <= 1'b1;
      sdaMeta_q <= 1'b1;
      sdaSync_q <= 1'b1;
      sdaPrev_q <= 1'b1;
    end else begin
      sclMeta_q <= scl_i;
      sclSync_q <= sclMeta_q;
      sclPrev_q <= sclSync_q;
      sdaMeta_q <= sda_i;
      sdaSync_q <= sdaMeta_q;
      sdaPrev_q <= sdaSync_q;
    end
  end

  assign sdaLevel_o = sdaSync_q;
  assign sclRise_o  = sclSync_q & ~sclPrev_q;
  assign sclFall_o  = ~sclSync_q & sclPrev_q;
  assign start_o    = sclSync_q & sclPrev_q & sdaPrev_q & ~sdaSync_q;
  assign stop_o     = sclSync_q & sclPrev_q & ~sdaPrev_q & sdaSync_q;

endmodule

// File: rtl/ssd1306_i2c_target.sv
// SSD1306 I2C write target: decodes address/control/command/data bytes,
// tracks display state and writes GDDRAM bytes with page addressing.
module ssd1306_i2c_target
  import ssd1306_pkg::*;
#(
  parameter logic [6:0] I2C_ADDR = DEFAULT_I2C_ADDR
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      scl,
  input  logic                      sda_in,
  output logic                      sda_oe,
  output logic                      fb_we,
  output logic [PAGE_W+COL_W-1:0]   fb_addr,
  output logic [7:0]                fb_wdata,
  output logic                      disp_on,
  output logic                      invert,
  output logic                      charge_pump,
  output logic [7:0]                contrast,
  output logic [1:0]                addr_mode,
  output logic                      frame_done
);

  logic sdaLevel, startDet, stopDet, sclRise, sclFall;

  i2c_line_sync uLineSync (
    .clk        (clk),
    .rst_n      (rst_n),
    .scl_i      (scl),
    .sda_i      (sda_in),
    .sdaLevel_o (sdaLevel),
    .start_o    (startDet),
    .stop_o     (stopDet),
    .sclRise_o  (sclRise),
    .sclFall_o  (sclFall)
  );

  i2cState_e          state_q, state_d;
  logic [2:0]         bitCnt_q, bitCnt_d;
  logic [6:0]         shift_q, shift_d;
  logic               ackHold_q, ackHold_d;
  logic               sdaOe_q, sdaOe_d;
  logic               co_q, co_d, dc_q, dc_d;
  logic               argPending_q, argPending_d;
  logic [7:0]         argOp_q, argOp_d;
  logic [PAGE_W-1:0]  page_q, page_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic               fbWe_q, fbWe_d, frameDone_q, frameDone_d;
  logic [PAGE_W+COL_W-1:0] fbAddr_q, fbAddr_d;
  logic [7:0]         fbWdata_q, fbWdata_d;
  logic               dispOn_q, dispOn_d, invert_q, invert_d, chargePump_q, chargePump_d;
  logic [7:0]         contrast_q, contrast_d;
  logic [1:0]         addrMode_q, addrMode_d;
  logic [7:0]         rxByte;
  logic               byteDone;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      bitCnt_q     <= '0;
      shift_q      <= '0;
      ackHold_q    <= 1'b0;
      sdaOe_q      <= 1'b0;
      co_q         <= 1'b0;
      dc_q         <= 1'b0;
      argPending_q <= 1'b0;
      argOp_q      <= '0;
      page_q       <= '0;
      col_q        <= '0;
      fbWe_q       <= 1'b0;
      fbAddr_q     <= '0;
      fbWdata_q    <= '0;
      frameDone_q  <= 1'b0;
      dispOn_q     <= 1'b0;
      invert_q     <= 1'b0;
      chargePump_q <= 1'b0;
      contrast_q   <= 8'h7F;
      addrMode_q   <= 2'b10;
    end else begin
      state_q      <= state_d;
      bitCnt_q     <= bitCnt_d;
      shift_q      <= shift_d;
      ackHold_q    <= ackHold_d;
      sdaOe_q      <= sdaOe_d;
      co_q         <= co_d;
      dc_q         <= dc_d;
      argPending_q <= argPending_d;
      argOp_q      <= argOp_d;
      page_q       <= page_d;
      col_q        <= col_d;
      fbWe_q       <= fbWe_d;
      fbAddr_q     <= fbAddr_d;
      fbWdata_q    <= fbWdata_d;
      frameDone_q  <= frameDone_d;
      dispOn_q     <= dispOn_d;
      invert_q     <= invert_d;
      chargePump_q <= chargePump_d;
      contrast_q   <= contrast_d;
      addrMode_q   <= addrMode_d;
    end
  end

  assign rxByte = {shift_q, sdaLevel};

  always_comb begin
    state_d      = state_q;
    bitCnt_d     = bitCnt_q;
    shift_d      = shift_q;
    ackHold_d    = ackHold_q;
    sdaOe_d      = sdaOe_q;
    co_d         = co_q;
    dc_d         = dc_q;
    argPending_d = argPending_q;
    argOp_d      = argOp_q;
    page_d       = page_q;
    col_d        = col_q;
    fbWe_d       = 1'b0;
    fbAddr_d     = fbAddr_q;
    fbWdata_d    = fbWdata_q;
    frameDone_d  = 1'b0;
    dispOn_d     = dispOn_q;
    invert_d     = invert_q;
    chargePump_d = chargePump_q;
    contrast_d   = contrast_q;
    addrMode_d   = addrMode_q;
    byteDone     = 1'b0;

    // Bus conditions pre-empt any same-cycle SCL edge and drop partial bytes.
    if (startDet) begin
      state_d   = ADDR;
      bitCnt_d  = '0;
      sdaOe_d   = 1'b0;
      ackHold_d = 1'b0;
    end else if (stopDet) begin
      state_d   = IDLE;
      sdaOe_d   = 1'b0;
      ackHold_d = 1'b0;
    end else begin
      unique case (state_q)
        ADDR, CTRL, BYTE: begin
          if (sclRise) begin
            shift_d  = rxByte[6:0];
            bitCnt_d = bitCnt_q + 3'd1;
            if (bitCnt_q == 3'd7) begin
              if (state_q == ADDR) begin
                state_d = (rxByte[7:1] == I2C_ADDR && !rxByte[0]) ? ACK_A : IGNORE;
              end else if (state_q == CTRL) begin
                co_d    = rxByte[7];
                dc_d    = rxByte[6];
                state_d = ACK_C;
              end else begin
                byteDone = 1'b1;
                state_d  = ACK_B;
              end
            end
          end
        end
        // First falling edge drives the ACK, the second one releases it.
        ACK_A, ACK_C, ACK_B: begin
          if (sclFall) begin
            if (!ackHold_q) begin
              sdaOe_d   = 1'b1;
              ackHold_d = 1'b1;
            end else begin
              sdaOe_d   = 1'b0;
              ackHold_d = 1'b0;
              if (state_q == ACK_A)      state_d = CTRL;
              else if (state_q == ACK_C) state_d = BYTE;
              else                       state_d = co_q ? CTRL : BYTE;
            end
          end
        end
        default: ;
      endcase
    end

    if (byteDone) begin
      if (dc_q) begin
        fbWe_d      = 1'b1;
        fbAddr_d    = {page_q, col_q};
        fbWdata_d   = rxByte;
        frameDone_d = (page_q == 3'd7) && (col_q == 7'd127);
        col_d       = col_q + 7'd1;
        if (col_q == 7'd127 && addrMode_q == 2'b00) page_d = page_q + 3'd1;
      end else if (argPending_q) begin
        argPending_d = 1'b0;
        if (argOp_q == OP_ADDR_MODE)        addrMode_d   = rxByte[1:0];
        else if (argOp_q == OP_CONTRAST)    contrast_d   = rxByte;
        else if (argOp_q == OP_CHARGE_PUMP) chargePump_d = rxByte[2];
      end else begin
        if (rxByte == OP_DISP_OFF)                   dispOn_d = 1'b0;
        else if (rxByte == OP_DISP_ON)               dispOn_d = 1'b1;
        else if (rxByte == OP_NORMAL)                invert_d = 1'b0;
        else if (rxByte == OP_INVERT)                invert_d = 1'b1;
        else if (rxByte[7:4] == 4'h0)                col_d[3:0] = rxByte[3:0];
        else if (rxByte[7:3] == 5'b00010)            col_d[6:4] = rxByte[2:0];
        else if (rxByte[7:3] == OP_PAGE_BASE[7:3])   page_d = rxByte[2:0];
        else if (isTwoByteOp(rxByte)) begin
          argPending_d = 1'b1;
          argOp_d      = rxByte;
        end
      end
    end
  end

  // Gated by reset so the pad lets go of SDA without waiting for a clock edge.
  assign sda_oe      = sdaOe_q & rst_n;
  assign fb_we       = fbWe_q;
  assign fb_addr     = fbAddr_q;
  assign fb_wdata    = fbWdata_q;
  assign frame_done  = frameDone_q;
  assign disp_on     = dispOn_q;
  assign invert      = invert_q;
  assign charge_pump = chargePump_q;
  assign contrast    = contrast_q;
  assign addr_mode   = addrMode_q;

endmodule

// File: tb/tb_ssd1306_i2c_target.sv
// Bit-banged I2C master driving ssd1306_i2c_target, with a frame-buffer write
// scoreboard and a table of command transactions.
module tb_ssd1306_i2c_target;

  localparam int Q = 3;
  localparam int H = 6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl = 1'b1;
  logic       masterSda = 1'b1;
  logic       sda_in;
  logic       sda_oe, fb_we, disp_on, invert, charge_pump, frame_done;
  logic [9:0] fb_addr;
  logic [7:0] fb_wdata, contrast;
  logic [1:0] addr_mode;

  assign sda_in = masterSda & ~sda_oe;

  always #10 clk = ~clk;

  ssd1306_i2c_target #(.I2C_ADDR(7'h3C)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .scl         (scl),
    .sda_in      (sda_in),
    .sda_oe      (sda_oe),
    .fb_we       (fb_we),
    .fb_addr     (fb_addr),
    .fb_wdata    (fb_wdata),
    .disp_on     (disp_on),
    .invert      (invert),
    .charge_pump (charge_pump),
    .contrast    (contrast),
    .addr_mode   (addr_mode),
    .frame_done  (frame_done)
  );

  typedef struct packed {
    logic [9:0] addr;
    logic [7:0] data;
    logic       frameDone;
  } fbExp_t;

  typedef struct {
    logic [7:0] cmd0;
    logic [7:0] cmd1;
    int         nCmd;
    logic       expDisp;
    logic       expInv;
    logic       expCp;
    logic [7:0] expContrast;
    logic [1:0] expMode;
  } cmdVec_t;

  fbExp_t     expQ[$];
  fbExp_t     monExp;
  logic [7:0] txBytes[$];
  cmdVec_t    vecs[11];
  int         checks = 0;
  int         errors = 0;
  int         ackCnt;
  logic       ack;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic expectWrite(input logic [9:0] addr, input logic [7:0] data, input logic fd);
    fbExp_t e;
    e.addr = addr;
    e.data = data;
    e.frameDone = fd;
    expQ.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (fb_we) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write", fb_addr, fb_wdata);
        end else begin
          monExp = expQ.pop_front();
          checkOutput("fb_addr", {22'd0, fb_addr}, {22'd0, monExp.addr});
          checkOutput("fb_wdata", {24'd0, fb_wdata}, {24'd0, monExp.data});
          checkOutput("frame_done", {31'd0, frame_done}, {31'd0, monExp.frameDone});
        end
      end else if (frame_done) begin
        checkOutput("stray_frame_done", 32'd1, 32'd0);
      end
    end
  end

  task automatic waitClk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2cStart();
    masterSda = 1'b1;
    waitClk(Q);
    scl = 1'b1;
    waitClk(H);
    masterSda = 1'b0;
    waitClk(H);
    scl = 1'b0;
    waitClk(Q);
  endtask

  task automatic i2cStop();
    masterSda = 1'b0;
    waitClk(Q);
    scl = 1'b1;
    waitClk(H);
    masterSda = 1'b1;
    waitClk(H);
  endtask

  task automatic i2cBits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      masterSda = b[i];
      waitClk(Q);
      scl = 1'b1;
      waitClk(H);
      scl = 1'b0;
      waitClk(Q);
    end
  endtask

  task automatic i2cByte(input logic [7:0] b, output logic ackOut);
    i2cBits(b, 8);
    masterSda = 1'b1;
    waitClk(Q);
    scl = 1'b1;
    waitClk(Q);
    ackOut = sda_oe;
    waitClk(Q);
    scl = 1'b0;
    waitClk(Q);
  endtask

  task automatic applyStimulus(output int acks);
    logic a;
    acks = 0;
    i2cStart();
    foreach (txBytes[k]) begin
      i2cByte(txBytes[k], a);
      if (a === 1'b1) acks++;
    end
    i2cStop();
    waitClk(4);
  endtask

  initial begin
    vecs[0]  = '{8'hAF, 8'hA7, 2, 1'b1, 1'b1, 1'b0, 8'h7F, 2'b10};
    vecs[1]  = '{8'h81, 8'hCF, 2, 1'b1, 1'b1, 1'b0, 8'hCF, 2'b10};
    vecs[2]  = '{8'h8D, 8'h14, 2, 1'b1, 1'b1, 1'b1, 8'hCF, 2'b10};
    vecs[3]  = '{8'hA6, 8'hAE, 2, 1'b0, 1'b0, 1'b1, 8'hCF, 2'b10};
    vecs[4]  = '{8'h20, 8'h00, 2, 1'b0, 1'b0, 1'b1, 8'hCF, 2'b00};
    vecs[5]  = '{8'h8D, 8'h10, 2, 1'b0, 1'b0, 1'b0, 8'hCF, 2'b00};
    vecs[6]  = '{8'h81, 8'hAF, 2, 1'b0, 1'b0, 1'b0, 8'hAF, 2'b00};
    vecs[7]  = '{8'hE3, 8'h00, 1, 1'b0, 1'b0, 1'b0, 8'hAF, 2'b00};
    vecs[8]  = '{8'h81, 8'h7F, 2, 1'b0, 1'b0, 1'b0, 8'h7F, 2'b00};
    vecs[9]  = '{8'h20, 8'h03, 2, 1'b0, 1'b0, 1'b0, 8'h7F, 2'b11};
    vecs[10] = '{8'h20, 8'h02, 2, 1'b0, 1'b0, 1'b0, 8'h7F, 2'b10};

    rst_n = 1'b0;
    waitClk(5);
    rst_n = 1'b1;
    waitClk(3);

    checkOutput("reset_sda_oe", {31'd0, sda_oe}, 32'd0);
    checkOutput("reset_fb_we", {31'd0, fb_we}, 32'd0);
    checkOutput("reset_fb_addr", {22'd0, fb_addr}, 32'd0);
    checkOutput("reset_fb_wdata", {24'd0, fb_wdata}, 32'd0);
    checkOutput("reset_disp_on", {31'd0, disp_on}, 32'd0);
    checkOutput("reset_invert", {31'd0, invert}, 32'd0);
    checkOutput("reset_charge_pump", {31'd0, charge_pump}, 32'd0);
    checkOutput("reset_contrast", {24'd0, contrast}, 32'h7F);
    checkOutput("reset_addr_mode", {30'd0, addr_mode}, 32'd2);
    checkOutput("reset_frame_done", {31'd0, frame_done}, 32'd0);

    txBytes = {8'h7A, 8'h00, 8'hAF};
    applyStimulus(ackCnt);
    checkOutput("addr3D_acks", ackCnt, 32'd0);
    checkOutput("addr3D_disp_on", {31'd0, disp_on}, 32'd0);
    txBytes = {8'h79, 8'h00, 8'hA7};
    applyStimulus(ackCnt);
    checkOutput("read_acks", ackCnt, 32'd0);
    checkOutput("read_invert", {31'd0, invert}, 32'd0);

    for (int v = 0; v < 11; v++) begin
      txBytes = {8'h78, 8'h00, vecs[v].cmd0};
      if (vecs[v].nCmd > 1) txBytes.push_back(vecs[v].cmd1);
      applyStimulus(ackCnt);
      checkOutput($sformatf("vec%0d_acks", v), ackCnt, vecs[v].nCmd + 2);
      checkOutput($sformatf("vec%0d_disp_on", v), {31'd0, disp_on}, {31'd0, vecs[v].expDisp});
      checkOutput($sformatf("vec%0d_invert", v), {31'd0, invert}, {31'd0, vecs[v].expInv});
      checkOutput($sformatf("vec%0d_charge_pump", v), {31'd0, charge_pump}, {31'd0, vecs[v].expCp});
      checkOutput($sformatf("vec%0d_contrast", v), {24'd0, contrast}, {24'd0, vecs[v].expContrast});
      checkOutput($sformatf("vec%0d_addr_mode", v), {30'd0, addr_mode}, {30'd0, vecs[v].expMode});
    end

    // Page mode: 129 bytes on page 3, the last one shows the column wrap.
    txBytes = {8'h78, 8'h00, 8'h00, 8'h10, 8'hB3};
    applyStimulus(ackCnt);
    checkOutput("pagecmd_acks", ackCnt, 32'd5);
    ackCnt = 0;
    i2cStart();
    i2cByte(8'h78, ack); if (ack === 1'b1) ackCnt++;
    i2cByte(8'h40, ack); if (ack === 1'b1) ackCnt++;
    for (int i = 0; i < 129; i++) begin
      expectWrite({3'd3, 7'(i)}, 8'(i), 1'b0);
      i2cByte(8'(i), ack);
      if (ack === 1'b1) ackCnt++;
    end
    i2cStop();
    waitClk(4);
    checkOutput("pagedata_acks", ackCnt, 32'd131);
    checkOutput("pagedata_pending", expQ.size(), 32'd0);

    // Horizontal mode from page 6: crosses into page 7, frame_done at 7/127, wraps to page 0.
    txBytes = {8'h78, 8'h00, 8'h20, 8'h00, 8'h00, 8'h10, 8'hB6};
    applyStimulus(ackCnt);
    checkOutput("horizcmd_addr_mode", {30'd0, addr_mode}, 32'd0);
    ackCnt = 0;
    i2cStart();
    i2cByte(8'h78, ack); if (ack === 1'b1) ackCnt++;
    i2cByte(8'h40, ack); if (ack === 1'b1) ackCnt++;
    for (int i = 0; i < 257; i++) begin
      expectWrite({3'(6 + i / 128), 7'(i)}, 8'(i ^ 8'h5A), (i == 255));
      i2cByte(8'(i ^ 8'h5A), ack);
      if (ack === 1'b1) ackCnt++;
    end
    i2cStop();
    waitClk(4);
    checkOutput("horizdata_acks", ackCnt, 32'd259);
    checkOutput("horizdata_pending", expQ.size(), 32'd0);

    // Co=1: every command byte is preceded by its own control byte.
    txBytes = {8'h78, 8'h80, 8'h81, 8'h80, 8'hCF, 8'h80, 8'hAF, 8'hC0, 8'h55};
    expectWrite(10'h001, 8'h55, 1'b0);
    applyStimulus(ackCnt);
    checkOutput("co_acks", ackCnt, 32'd9);
    checkOutput("co_contrast", {24'd0, contrast}, 32'hCF);
    checkOutput("co_disp_on", {31'd0, disp_on}, 32'd1);
    checkOutput("co_pending", expQ.size(), 32'd0);

    // Partial data bytes cut by STOP and by repeated START must not write.
    i2cStart();
    i2cByte(8'h78, ack);
    i2cByte(8'h40, ack);
    i2cBits(8'hF0, 4);
    i2cStop();
    waitClk(4);
    ackCnt = 0;
    i2cStart();
    i2cByte(8'h78, ack); if (ack === 1'b1) ackCnt++;
    i2cByte(8'h40, ack); if (ack === 1'b1) ackCnt++;
    i2cBits(8'h0F, 4);
    i2cStart();
    i2cByte(8'h78, ack); if (ack === 1'b1) ackCnt++;
    i2cByte(8'h40, ack); if (ack === 1'b1) ackCnt++;
    expectWrite(10'h002, 8'hAA, 1'b0);
    i2cByte(8'hAA, ack); if (ack === 1'b1) ackCnt++;
    i2cStop();
    waitClk(4);
    checkOutput("abort_acks", ackCnt, 32'd5);
    checkOutput("abort_pending", expQ.size(), 32'd0);

    // Reset asserted while the target holds the address ACK.
    i2cStart();
    i2cBits(8'h78, 8);
    masterSda = 1'b1;
    waitClk(Q);
    scl = 1'b1;
    waitClk(Q);
    checkOutput("ack_before_reset", {31'd0, sda_oe}, 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("reset_in_ack_sda_oe", {31'd0, sda_oe}, 32'd0);
    checkOutput("reset_in_ack_contrast", {24'd0, contrast}, 32'h7F);
    checkOutput("reset_in_ack_disp_on", {31'd0, disp_on}, 32'd0);
    waitClk(3);
    scl = 1'b0;
    waitClk(2);
    rst_n = 1'b1;
    waitClk(3);
    i2cStop();
    waitClk(4);
    txBytes = {8'h78, 8'h00, 8'hAF};
    applyStimulus(ackCnt);
    checkOutput("post_reset_acks", ackCnt, 32'd3);
    checkOutput("post_reset_disp_on", {31'd0, disp_on}, 32'd1);
    checkOutput("final_pending", expQ.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
